// File: rtl/kt_pkg.sv
// ============================================================================
// kt_pkg : shared types and constants for the knight's-tour job scheduler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package kt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_GAP    = 3'd4
  } kt_state_e;

  localparam int KT_N       = 5;
  localparam int KT_STEPS   = 25;
  localparam int KT_COORD_W = 3;
  localparam int KT_STEP_W  = 5;

  // Largest legal coordinate on the 5x5 board
  localparam logic [KT_COORD_W-1:0] KT_MAX_COORD = KT_COORD_W'(KT_N - 1);

  localparam logic [2:0] KT_DIR_0 = 3'd0;
  localparam logic [2:0] KT_DIR_1 = 3'd1;
  localparam logic [2:0] KT_DIR_2 = 3'd2;
  localparam logic [2:0] KT_DIR_3 = 3'd3;
  localparam logic [2:0] KT_DIR_4 = 3'd4;
  localparam logic [2:0] KT_DIR_5 = 3'd5;
  localparam logic [2:0] KT_DIR_6 = 3'd6;
  localparam logic [2:0] KT_DIR_7 = 3'd7;

endpackage

`default_nettype wire

// File: rtl/kt_rr_arb.sv
// ============================================================================
// kt_rr_arb : round-robin arbiter, grants first request at or after ptr
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module kt_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int k;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
        any     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/kt_job_sched.sv
// ============================================================================
// kt_job_sched : round-robin front end sharing one knight's-tour solver,
//                forwarding its 25-beat tour back tagged with requester ID
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module kt_job_sched
  import kt_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TO_CYC = 50000,
  parameter int CYC_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [KT_COORD_W*N_REQ-1:0] req_x,
  input  logic [KT_COORD_W*N_REQ-1:0] req_y,
  input  logic [3*N_REQ-1:0]          req_pri,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        kt_in_valid,
  output logic [KT_COORD_W-1:0]       kt_in_x,
  output logic [KT_COORD_W-1:0]       kt_in_y,
  output logic [KT_STEP_W-1:0]        kt_move_num,
  output logic [2:0]                  kt_priority_num,
  input  logic                        kt_out_valid,
  input  logic [KT_COORD_W-1:0]       kt_out_x,
  input  logic [KT_COORD_W-1:0]       kt_out_y,
  input  logic [KT_STEP_W-1:0]        kt_move_out,
  output logic                        rsp_valid,
  output logic [$clog2(N_REQ)-1:0]    rsp_id,
  output logic [KT_COORD_W-1:0]       rsp_x,
  output logic [KT_COORD_W-1:0]       rsp_y,
  output logic [KT_STEP_W-1:0]        rsp_step,
  output logic                        rsp_last,
  output logic                        rsp_err,
  output logic [CYC_W-1:0]            rsp_cycles,
  output logic                        busy,
  output logic                        err_timeout,
  output logic                        err_proto
);

  localparam int ID_W = $clog2(N_REQ);

  kt_state_e                 r_state, w_next;
  logic [ID_W-1:0]           r_ptr, r_id;
  logic [KT_COORD_W-1:0]     r_x, r_y;
  logic [2:0]                r_pri;
  logic [CYC_W-1:0]          r_cnt;
  logic [KT_STEP_W-1:0]      r_beat;

  logic [N_REQ-1:0]          w_gnt;
  logic [ID_W-1:0]           w_gnt_idx;
  logic                      w_any;
  logic [KT_COORD_W-1:0]     w_win_x, w_win_y;
  logic [2:0]                w_win_pri;
  logic                      w_bad;
  logic [ID_W-1:0]           w_ptr_nx;
  logic [KT_STEP_W-1:0]      w_beat_nx;
  logic [CYC_W-1:0]          w_cnt_inc;
  logic                      w_in_job, w_fwd, w_abort, w_accept;

  kt_rr_arb #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_comb begin
    w_win_x   = '0;
    w_win_y   = '0;
    w_win_pri = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_x   = req_x[KT_COORD_W*i +: KT_COORD_W];
        w_win_y   = req_y[KT_COORD_W*i +: KT_COORD_W];
        w_win_pri = req_pri[3*i +: 3];
      end
    end
  end

  assign w_bad     = (w_win_x > KT_MAX_COORD) || (w_win_y > KT_MAX_COORD);
  assign w_ptr_nx  = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_beat_nx = r_beat + 1'b1;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_in_job  = (r_state == ST_WAIT) || (r_state == ST_STREAM);
  assign w_fwd     = kt_out_valid && w_in_job;
  assign w_abort   = (r_state == ST_STREAM) && !kt_out_valid;
  assign w_accept  = (r_state == ST_IDLE) && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready = w_gnt;
          w_next    = w_bad ? ST_GAP : ST_ISSUE;
        end
      end
      ST_ISSUE:  w_next = ST_WAIT;
      ST_WAIT:   if (kt_out_valid) w_next = ST_STREAM;
      ST_STREAM: begin
        if (!kt_out_valid || (w_beat_nx == KT_STEP_W'(KT_STEPS))) w_next = ST_GAP;
      end
      ST_GAP:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign busy            = (r_state != ST_IDLE);
  assign kt_in_valid     = (r_state == ST_ISSUE);
  assign kt_in_x         = kt_in_valid ? r_x : '0;
  assign kt_in_y         = kt_in_valid ? r_y : '0;
  assign kt_priority_num = kt_in_valid ? r_pri : '0;
  assign kt_move_num     = kt_in_valid ? KT_STEP_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_pri       <= KT_DIR_0;
      r_cnt       <= '0;
      r_beat      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      rsp_step    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_cycles  <= '0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;

      if (w_accept) begin
        r_ptr  <= w_ptr_nx;
        r_id   <= w_gnt_idx;
        r_x    <= w_win_x;
        r_y    <= w_win_y;
        r_pri  <= w_win_pri;
        r_cnt  <= '0;
        r_beat <= '0;
        // Off-board start: answer with a single error beat, solver untouched
        if (w_bad) begin
          rsp_valid  <= 1'b1;
          rsp_last   <= 1'b1;
          rsp_err    <= 1'b1;
          rsp_id     <= w_gnt_idx;
          rsp_x      <= '0;
          rsp_y      <= '0;
          rsp_step   <= '0;
          rsp_cycles <= '0;
        end
      end

      if ((r_state == ST_WAIT) && (r_cnt != '1)) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == CYC_W'(TO_CYC)) err_timeout <= 1'b1;
      end

      if (w_fwd) begin
        rsp_valid <= 1'b1;
        rsp_id    <= r_id;
        rsp_x     <= kt_out_x;
        rsp_y     <= kt_out_y;
        rsp_step  <= kt_move_out;
        r_beat    <= w_beat_nx;
        if (kt_move_out != w_beat_nx) err_proto <= 1'b1;
        if (w_beat_nx == KT_STEP_W'(KT_STEPS)) begin
          rsp_last   <= 1'b1;
          rsp_cycles <= r_cnt;
        end
      end

      // Solver went quiet mid-tour: close the job with an error beat
      if (w_abort) begin
        err_proto  <= 1'b1;
        rsp_valid  <= 1'b1;
        rsp_last   <= 1'b1;
        rsp_err    <= 1'b1;
        rsp_id     <= r_id;
        rsp_x      <= '0;
        rsp_y      <= '0;
        rsp_step   <= w_beat_nx;
        rsp_cycles <= r_cnt;
      end

      if (kt_out_valid && !w_in_job) err_proto <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kt_job_sched.sv
// ============================================================================
// tb_kt_job_sched : scoreboard bench with behavioural solver and RR model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_kt_job_sched;

  localparam int N  = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [3*N-1:0]  req_x = '0, req_y = '0, req_pri = '0;
  logic [N-1:0]    req_ready;
  logic            kt_in_valid;
  logic [2:0]      kt_in_x, kt_in_y, kt_priority_num;
  logic [4:0]      kt_move_num;
  logic            kt_out_valid = 1'b0;
  logic [2:0]      kt_out_x = '0, kt_out_y = '0;
  logic [4:0]      kt_move_out = '0;
  logic            rsp_valid, rsp_last, rsp_err, busy, err_timeout, err_proto;
  logic [1:0]      rsp_id;
  logic [2:0]      rsp_x, rsp_y;
  logic [4:0]      rsp_step;
  logic [CW-1:0]   rsp_cycles;
  logic [53:0]     outs;

  kt_job_sched #(.N_REQ(N), .TO_CYC(100), .CYC_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_pri(req_pri),
    .req_ready(req_ready),
    .kt_in_valid(kt_in_valid), .kt_in_x(kt_in_x), .kt_in_y(kt_in_y),
    .kt_move_num(kt_move_num), .kt_priority_num(kt_priority_num),
    .kt_out_valid(kt_out_valid), .kt_out_x(kt_out_x), .kt_out_y(kt_out_y),
    .kt_move_out(kt_move_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_step(rsp_step), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rsp_cycles(rsp_cycles), .busy(busy),
    .err_timeout(err_timeout), .err_proto(err_proto)
  );

  assign outs = {req_ready, kt_in_valid, kt_in_x, kt_in_y, kt_move_num, kt_priority_num,
                 rsp_valid, rsp_id, rsp_x, rsp_y, rsp_step, rsp_last, rsp_err,
                 rsp_cycles, busy, err_timeout, err_proto};

  typedef struct {
    int id; int x; int y; int step; int last; int err; int cyc; int cycles;
  } exp_t;

  exp_t exp_q[$];
  int   glog[$];
  int   n_checks = 0, n_fail = 0, cyc = 0;
  int   model_ptr = 0, grant_count = 0, acc_cyc = 0, cur_id = 0;
  int   g_x = 0, g_y = 0, g_pri = 0, issues = 0, exp_issues = 0;
  int   sol_lat = 0, sol_drop = 0, sol_beat = 0;
  bit   sol_active = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin reference and job-issue checks
  initial forever begin
    int w;
    @(negedge clk);
    if (!rst_n) model_ptr = 0;
    else begin
      if (req_ready != '0) chk("ready_only_in_idle", busy, 0);
      if (!busy && req_valid != '0) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && req_valid[(model_ptr + i) % N]) w = (model_ptr + i) % N;
        chk("grant_onehot", req_ready, 1 << w);
        model_ptr = (w + 1) % N;
        grant_count++;
        glog.push_back(w);
        acc_cyc = cyc;
        cur_id  = w;
        g_x   = int'(req_x[3*w +: 3]);
        g_y   = int'(req_y[3*w +: 3]);
        g_pri = int'(req_pri[3*w +: 3]);
        if (g_x > 4 || g_y > 4)
          exp_q.push_back('{id: w, x: -1, y: -1, step: 0, last: 1, err: 1,
                            cyc: cyc + 1, cycles: 0});
        else
          exp_issues++;
      end
      if (kt_in_valid) begin
        issues++;
        chk("issue_timing", cyc, acc_cyc + 1);
        chk("issue_job", {kt_in_x, kt_in_y, kt_priority_num, kt_move_num},
            (g_x << 11) | (g_y << 8) | (g_pri << 5) | 1);
      end
    end
  end

  // Response scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) exp_q.delete();
    else if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_tag", {rsp_id, rsp_step, rsp_last, rsp_err},
            (e.id << 7) | (e.step << 2) | (e.last << 1) | e.err);
        if (e.x >= 0) chk("rsp_xy", {rsp_x, rsp_y}, (e.x << 3) | e.y);
        if (e.cycles >= 0) chk("rsp_cycles", rsp_cycles, e.cycles);
      end
    end
  end

  // Behavioural solver: fixed latency then 25 consecutive tour beats
  initial forever begin
    int lat, drop, jid, bx, by;
    @(negedge clk);
    if (rst_n && kt_in_valid) begin
      jid  = cur_id;
      drop = sol_drop;
      lat  = (sol_lat > 0) ? sol_lat : int'($urandom_range(1, 40));
      sol_active = 1'b1;
      repeat (lat) @(posedge clk);
      #1;
      for (int k = 1; k <= 25; k++) begin
        if (!rst_n) break;
        if (drop != 0 && k > drop) begin
          kt_out_valid = 1'b0;
          exp_q.push_back('{id: jid, x: -1, y: -1, step: k, last: 1, err: 1,
                            cyc: cyc + 1, cycles: -1});
          break;
        end
        bx = int'($urandom_range(0, 4));
        by = int'($urandom_range(0, 4));
        kt_out_valid = 1'b1;
        kt_out_x     = 3'(bx);
        kt_out_y     = 3'(by);
        kt_move_out  = 5'(k);
        exp_q.push_back('{id: jid, x: bx, y: by, step: k, last: (k == 25), err: 0,
                          cyc: cyc + 1, cycles: (k == 25) ? lat : -1});
        sol_beat = k;
        @(posedge clk);
        #1;
      end
      kt_out_valid = 1'b0;
      sol_beat     = 0;
      sol_active   = 1'b0;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input int id, input int x, input int y, input int pri);
    int n;
    @(posedge clk);
    #1;
    req_valid[id]     = 1'b1;
    req_x[3*id +: 3]  = 3'(x);
    req_y[3*id +: 3]  = 3'(y);
    req_pri[3*id +: 3] = 3'(pri);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[id] && n < 500);
    chk("req_accepted", req_ready[id], 1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || sol_active || exp_q.size() != 0) && n < budget);
    chk("job_completes", busy || sol_active || (exp_q.size() != 0), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int i0, n;
    apply_reset();
    @(negedge clk);
    chk("reset_outputs", outs, 0);

    // Single job with a known latency
    sol_lat = 7;
    do_req(0, 0, 0, 0);
    wait_done(200);
    chk("single_err_proto", err_proto, 0);
    chk("single_err_timeout", err_timeout, 0);

    // Fairness: all requesters held valid from rr_ptr = 0
    apply_reset();
    sol_lat = 0;
    glog.delete();
    i0 = grant_count;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_x[3*i +: 3]   = 3'($urandom_range(0, 4));
      req_y[3*i +: 3]   = 3'($urandom_range(0, 4));
      req_pri[3*i +: 3] = 3'($urandom_range(0, 7));
    end
    req_valid = '1;
    n = 0;
    while (grant_count - i0 < 5 && n < 2000) begin @(posedge clk); #1; n++; end
    req_valid = '0;
    chk("fair_grant_count", grant_count - i0, 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("fair_order", glog[i], i % 4);
    wait_done(200);

    // Reject path
    i0 = issues;
    do_req(2, 5, 1, 3);
    wait_done(20);
    chk("reject_no_issue", issues - i0, 0);

    // Randomised jobs, including off-board starts
    for (int j = 0; j < 10; j++) begin
      do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      wait_done(200);
    end
    chk("random_err_proto", err_proto, 0);

    // Protocol abort after beat 10, then a normal job
    sol_lat  = 5;
    sol_drop = 10;
    do_req(1, 2, 3, 4);
    wait_done(200);
    sol_drop = 0;
    chk("abort_err_proto", err_proto, 1);
    do_req(3, 4, 4, 7);
    wait_done(200);

    // Timeout: silent solver for 150 cycles
    sol_lat = 150;
    do_req(0, 1, 2, 5);
    n = 0;
    do begin @(negedge clk); n++; end while (!kt_in_valid && n < 10);
    chk("timeout_issue_seen", kt_in_valid, 1);
    repeat (100) @(negedge clk);
    chk("timeout_before", err_timeout, 0);
    @(negedge clk);
    chk("timeout_rise", err_timeout, 1);
    wait_done(400);
    chk("timeout_sticky", err_timeout, 1);

    // Reset in the middle of the tour stream
    sol_lat = 4;
    do_req(1, 0, 4, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (sol_beat != 12 && n < 200);
    chk("reset_beat12_seen", sol_beat, 12);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", outs, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sol_lat = 0;
    do_req(2, 3, 3, 1);
    wait_done(200);
    chk("post_reset_err_proto", err_proto, 0);
    chk("post_reset_err_timeout", err_timeout, 0);

    chk("issue_total", issues, exp_issues);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
